// File: rtl/pkt_cell_writer.sv
// rtl/pkt_cell_writer.sv - chops an ingress byte stream into linked memory cells with per-cell footers.
// Optional statistics counters are enabled with `define PKT_CELL_WRITER_STATS_EN.
module pkt_cell_writer #(
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_BLOCKS  = 64,
  localparam int ADDR_W = $clog2(NUM_BLOCKS),
  localparam int OFF_W  = $clog2(BLOCK_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    alloc_req,
  input  logic                    alloc_gnt,
  input  logic [ADDR_W-1:0]       alloc_idx,
  output logic                    mem_we,
  output logic [ADDR_W+OFF_W-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    head_valid,
  input  logic                    head_ready,
  output logic [ADDR_W-1:0]       head_idx,
  output logic [11:0]             head_len
`ifdef PKT_CELL_WRITER_STATS_EN
  ,
  output logic [15:0]             stat_pkts,
  output logic [15:0]             stat_cells
`endif
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ALLOC_HEAD = 3'd1;
  localparam logic [2:0] WRITE      = 3'd2;
  localparam logic [2:0] ALLOC_NEXT = 3'd3;
  localparam logic [2:0] FOOT_LAST  = 3'd4;
  localparam logic [2:0] HEAD_OUT   = 3'd5;

  // The last byte of every cell is the footer; payload fills the offsets before it.
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_BYTES - 2);
  localparam logic [OFF_W-1:0] FOOT_OFF = OFF_W'(BLOCK_BYTES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_idx;
  logic [OFF_W-1:0]  off;
  logic [11:0]       len;

  assign s_ready    = (state == WRITE);
  assign alloc_req  = (state == ALLOC_HEAD) || (state == ALLOC_NEXT);
  assign head_valid = (state == HEAD_OUT);
  assign head_len   = len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_idx   <= '0;
      head_idx  <= '0;
      off       <= '0;
      len       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) state <= ALLOC_HEAD;
        end
        ALLOC_HEAD: begin
          if (alloc_gnt) begin
            cur_idx  <= alloc_idx;
            head_idx <= alloc_idx;
            off      <= '0;
            len      <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (s_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= {cur_idx, off};
            mem_wdata <= s_data;
            off       <= off + 1'b1;
            if (len != 12'hFFF) len <= len + 12'd1;
            if (s_last) state <= FOOT_LAST;
            else if (off == LAST_OFF) state <= ALLOC_NEXT;
          end
        end
        ALLOC_NEXT: begin
          // Footer links the full cell to the freshly granted one.
          if (alloc_gnt) begin
            mem_we    <= 1'b1;
            mem_addr  <= {cur_idx, FOOT_OFF};
            mem_wdata <= 8'({alloc_idx, 2'b00});
            cur_idx   <= alloc_idx;
            off       <= '0;
            state     <= WRITE;
          end
        end
        FOOT_LAST: begin
          mem_we    <= 1'b1;
          mem_addr  <= {cur_idx, FOOT_OFF};
          mem_wdata <= 8'h02;
          state     <= HEAD_OUT;
        end
        HEAD_OUT: begin
          if (head_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_CELL_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_cells <= '0;
    end else begin
      if (head_valid && head_ready) stat_pkts <= stat_pkts + 16'd1;
      if (alloc_req && alloc_gnt) stat_cells <= stat_cells + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_cell_writer.sv
// tb/tb_pkt_cell_writer.sv - self-checking bench for pkt_cell_writer against a cell-layout reference model.
module tb_pkt_cell_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [5:0]  alloc_idx;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        head_valid;
  logic        head_ready;
  logic [5:0]  head_idx;
  logic [11:0] head_len;

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];

  pkt_cell_writer dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .head_idx   (head_idx),
    .head_len   (head_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) got.push_back({20'd0, mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs();
    check("rst_s_ready", s_ready, 0);
    check("rst_alloc_req", alloc_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_head_idx", head_idx, 0);
    check("rst_head_len", head_len, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  // Payload byte q lands in cell q/63 at offset q%63; each cell ends with a footer at offset 63.
  task automatic run_pkt(input int len, input int gnt_pct, input int idx0, input int idx1, input int d0,
                         input int stall_n, input int hold_n, input int abort_at);
    logic [7:0] data[$];
    int idx[$];
    int expw[$];
    int n, p, g, cyc, stall_left, stall_cnt, hold_left, prev_q;
    bit done, aborted, prev_acc, stalling;
    n = (len + 62) / 63;
    for (int i = 0; i < len; i++) data.push_back(8'($urandom));
    if (d0 >= 0) data[0] = 8'(d0);
    for (int k = 0; k < n; k++) idx.push_back(int'($urandom_range(63)));
    if (idx0 >= 0) idx[0] = idx0;
    if (idx1 >= 0 && n > 1) idx[1] = idx1;
    for (int k = 0; k < n; k++) begin
      for (int i = k * 63; i < len && i < (k + 1) * 63; i++)
        expw.push_back(((idx[k] * 64 + i % 63) << 8) | int'(data[i]));
      if (k < n - 1) expw.push_back(((idx[k] * 64 + 63) << 8) | (idx[k + 1] << 2));
      else expw.push_back(((idx[k] * 64 + 63) << 8) | 2);
    end

    got.delete();
    p = 0; g = 0; cyc = 0; prev_q = 0;
    done = 0; aborted = 0; prev_acc = 0;
    stall_left = stall_n; stall_cnt = 0; hold_left = hold_n;
    while (!done && !aborted && cyc < 20000) begin
      s_valid = (p < len) && ($urandom_range(99) < 80);
      s_data  = (p < len) ? data[p] : 8'h00;
      s_last  = (p == len - 1);
      stalling  = alloc_req && (g > 0) && (stall_left > 0);
      alloc_gnt = stalling ? 1'b0 : ($urandom_range(99) < gnt_pct);
      alloc_idx = 6'((g < n) ? idx[g] : int'($urandom));
      if (head_valid && hold_left > 0) begin
        head_ready = 1'b0;
        hold_left--;
      end else begin
        head_ready = head_valid ? 1'b1 : 1'($urandom_range(1));
      end
      @(negedge clk);
      if (prev_acc) begin
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, idx[prev_q / 63] * 64 + prev_q % 63);
        check("wr_data", mem_wdata, data[prev_q]);
      end
      prev_acc = s_valid && s_ready;
      prev_q = p;
      if (stalling) begin
        check("stall_s_ready", s_ready, 0);
        if (stall_cnt > 0) check("stall_mem_we", mem_we, 0);
        stall_cnt++;
        stall_left--;
      end
      if (alloc_req) check("alloc_s_ready", s_ready, 0);
      if (s_valid && s_ready) begin
        p++;
        if (p == abort_at) aborted = 1;
      end
      if (alloc_req && alloc_gnt) begin
        if (g >= n) check("extra_alloc", g, n - 1);
        g++;
      end
      if (head_valid) begin
        check("head_idx", head_idx, idx[0]);
        check("head_len", head_len, (len > 4095) ? 4095 : len);
        check("head_s_ready", s_ready, 0);
        check("head_alloc_req", alloc_req, 0);
        if (head_ready) done = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end

    s_valid = 1'b0; s_last = 1'b0; alloc_gnt = 1'b0; head_ready = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      check("abort_wr_cnt", got.size(), abort_at);
      for (int i = 0; i < got.size() && i < abort_at; i++) check("abort_wr", got[i], expw[i]);
    end else begin
      check("pkt_done", done, 1);
      check("alloc_cnt", g, n);
      @(negedge clk);
      check("idle_head_valid", head_valid, 0);
      check("idle_alloc_req", alloc_req, 0);
      check("idle_s_ready", s_ready, 0);
      check("wr_cnt", got.size(), expw.size());
      for (int i = 0; i < got.size() && i < expw.size(); i++) check("wr", got[i], expw[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    alloc_gnt = 1'b0; alloc_idx = 6'd0; head_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_pkt(1, 100, 5, -1, 8'hA5, 0, 0, -1);
    run_pkt(63, 100, 5, -1, -1, 0, 0, -1);
    run_pkt(64, 100, 5, 9, -1, 0, 0, -1);
    run_pkt(130, 100, -1, -1, -1, 10, 0, -1);
    run_pkt(20, 100, -1, -1, -1, 0, 5, -1);
    run_pkt(40, 100, -1, -1, -1, 0, 0, 30);
    run_pkt(1, 100, 5, -1, 8'hA5, 0, 0, -1);
    run_pkt(4100, 100, -1, -1, -1, 0, 0, -1);
    for (int t = 0; t < 15; t++)
      run_pkt(int'($urandom_range(1, 200)), int'($urandom_range(30, 100)), -1, -1, -1, 0,
              int'($urandom_range(0, 3)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
